// File: rtl/mdu_if.sv
// Bundled E-stage request / HI-LO response signals between the pipeline and the MDU.
interface mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDUOp, start, input busy, HI, LO);
  modport slave  (input A, B, MDUOp, start, output busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers.
// The result is computed when the request is accepted and parked in pHI/pLO;
// a down-counter then models the multi-cycle latency before HI/LO commit.
// Optional feature macro: MDU_MADD_EN adds madd/maddu/msub/msubu (ops 7-10).
module mdu (
  input  logic  clk,
  input  logic  rst_n,
  mdu_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic        busy_q;
  logic [31:0] hi_q, lo_q, phi, plo;

  logic [31:0] a, b;
  logic [63:0] prod_s, prod_u, res;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, sq, sr, uq, ur;
  logic        launch;
  logic [3:0]  len;
  logic        go, mt;

  assign a = bus.A;
  assign b = bus.B;

  // Arithmetic datapath: products and both flavours of division
  always_comb begin
    // sign-extended 64x64 product truncated to 64 bits equals the signed product
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    // divide by zero never commits, so substitute 1 to keep the divider well-defined
    b_div  = (b == 32'd0) ? 32'd1 : b;
    a_mag  = a[31] ? (~a + 32'd1) : a;
    b_mag  = b_div[31] ? (~b_div + 32'd1) : b_div;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    // quotient truncates toward zero; remainder takes the dividend's sign
    sq     = (a[31] ^ b_div[31]) ? (~q_mag + 32'd1) : q_mag;
    sr     = a[31] ? (~r_mag + 32'd1) : r_mag;
    uq     = a / b_div;
    ur     = a % b_div;
  end

  // Opcode decode: which ops launch, their latency, and the pending result
  always_comb begin
    launch = 1'b0;
    len    = 4'd0;
    res    = {hi_q, lo_q};
    case (bus.MDUOp)
      OP_MULT:  begin launch = 1'b1; len = 4'd5;  res = prod_s; end
      OP_MULTU: begin launch = 1'b1; len = 4'd5;  res = prod_u; end
      OP_DIV: begin
        launch = 1'b1; len = 4'd10;
        if (b != 32'd0) res = {sr, sq};
      end
      OP_DIVU: begin
        launch = 1'b1; len = 4'd10;
        if (b != 32'd0) res = {ur, uq};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin launch = 1'b1; len = 4'd5; res = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin launch = 1'b1; len = 4'd5; res = {hi_q, lo_q} + prod_u; end
      OP_MSUB:  begin launch = 1'b1; len = 4'd5; res = {hi_q, lo_q} - prod_s; end
      OP_MSUBU: begin launch = 1'b1; len = 4'd5; res = {hi_q, lo_q} - prod_u; end
`endif
      default: ;
    endcase
  end

  // Requests only take effect while idle; anything presented during RUN is dropped
  assign go = (state == IDLE) && bus.start && launch;
  assign mt = (state == IDLE) && ((bus.MDUOp == OP_MTHI) || (bus.MDUOp == OP_MTLO));

  // Control FSM, latency counter, pending result and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      phi    <= 32'd0;
      plo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            phi    <= res[63:32];
            plo    <= res[31:0];
            cnt    <= len;
            busy_q <= 1'b1;
            state  <= RUN;
          end else if (mt) begin
            if (bus.MDUOp == OP_MTHI) hi_q <= a;
            else                      lo_q <= a;
          end
        end
        default: begin
          if (cnt == 4'd1) begin
            hi_q   <= phi;
            lo_q   <= plo;
            cnt    <= 4'd0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule
